// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 @ 60 Hz raster timing and shared types
// for the video sync generator. The optional coordinate outputs of the
// generator are enabled with the VSG_PIXEL_COORD_EN macro.
package vga_timing_pkg;

  // Default horizontal timing, in pixel clocks
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;

  // Default vertical timing, in lines
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  // Derived raster totals (800 x 525)
  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;

  // Active window bounds, half-open [start, end)
  localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int H_ACT_END   = H_ACT_START + DEF_H_ACTIVE;
  localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BACK;
  localparam int V_ACT_END   = V_ACT_START + DEF_V_ACTIVE;

  // Raster counter / coordinate type
  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vsg_axis_counter.sv
// vsg_axis_counter: one raster axis (horizontal or vertical). Counts
// 0..TOTAL-1 while enabled and decodes sync, active window and the offset
// into the active window from the current count.
module vsg_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL     = H_TOTAL,
  parameter int SYNC      = DEF_H_SYNC,
  parameter int ACT_START = H_ACT_START,
  parameter int ACT_LEN   = DEF_H_ACTIVE
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  output coord_t count,
  output logic   wrap,
  output logic   sync_n,
  output logic   active,
  output coord_t offset
);

  localparam coord_t LastC  = coord_t'(TOTAL - 1);
  localparam coord_t SyncC  = coord_t'(SYNC);
  localparam coord_t StartC = coord_t'(ACT_START);
  localparam coord_t EndC   = coord_t'(ACT_START + ACT_LEN);

  coord_t count_r;

  // Axis position counter: advances when enabled, wraps after TOTAL-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 10'd0;
    end else if (enable) begin
      if (count_r == LastC) begin
        count_r <= 10'd0;
      end else begin
        count_r <= count_r + 10'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Decode wrap, sync and active window from the current count
  always_comb begin
    wrap   = 1'b0;
    sync_n = 1'b1;
    active = 1'b0;
    offset = 10'd0;
    if (enable && (count_r == LastC)) begin
      wrap = 1'b1;
    end else begin
      wrap = 1'b0;
    end
    if (count_r < SyncC) begin
      sync_n = 1'b0;
    end else begin
      sync_n = 1'b1;
    end
    if ((count_r >= StartC) && (count_r < EndC)) begin
      active = 1'b1;
      offset = count_r - StartC;
    end else begin
      active = 1'b0;
      offset = 10'd0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/video_sync_generator.sv
// video_sync_generator: VGA raster timing (default 640x480 @ 60 Hz).
// Produces registered active-low HS/VS and active-high blank_n, one clock
// behind the raster counters. Defining VSG_PIXEL_COORD_EN adds the
// pixel_x / pixel_y / frame_start outputs and their registers.
module video_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic   vga_clk,
  input  logic   reset,
  output logic   blank_n,
  output logic   HS,
  output logic   VS
`ifdef VSG_PIXEL_COORD_EN
  ,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   frame_start
`endif
);

  localparam int HTotal = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VTotal = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  coord_t hCount_s;
  coord_t vCount_s;
  coord_t hOffset_s;
  coord_t vOffset_s;
  logic   hWrap_s;
  logic   vWrap_s;
  logic   hSyncN_s;
  logic   vSyncN_s;
  logic   hActive_s;
  logic   vActive_s;
  logic   blankNext_s;

  logic   hs_r;
  logic   vs_r;
  logic   blank_r;

  vsg_axis_counter #(
    .TOTAL     (HTotal),
    .SYNC      (H_SYNC),
    .ACT_START (H_SYNC + H_BACK),
    .ACT_LEN   (H_ACTIVE)
  ) uHAxis (
    .clk    (vga_clk),
    .rst    (reset),
    .enable (1'b1),
    .count  (hCount_s),
    .wrap   (hWrap_s),
    .sync_n (hSyncN_s),
    .active (hActive_s),
    .offset (hOffset_s)
  );

  // The vertical axis steps once per line, on the horizontal wrap, so both
  // axes return to the raster origin on the same clock.
  vsg_axis_counter #(
    .TOTAL     (VTotal),
    .SYNC      (V_SYNC),
    .ACT_START (V_SYNC + V_BACK),
    .ACT_LEN   (V_ACTIVE)
  ) uVAxis (
    .clk    (vga_clk),
    .rst    (reset),
    .enable (hWrap_s),
    .count  (vCount_s),
    .wrap   (vWrap_s),
    .sync_n (vSyncN_s),
    .active (vActive_s),
    .offset (vOffset_s)
  );

  // Display enable is the intersection of both axis windows
  always_comb begin
    blankNext_s = 1'b0;
    if (hActive_s && vActive_s) begin
      blankNext_s = 1'b1;
    end else begin
      blankNext_s = 1'b0;
    end
  end

  // Sync and blank output registers (idle: syncs high, blanked)
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_r <= 1'b0;
    end else begin
      hs_r    <= hSyncN_s;
      vs_r    <= vSyncN_s;
      blank_r <= blankNext_s;
    end
  end

  assign HS      = hs_r;
  assign VS      = vs_r;
  assign blank_n = blank_r;

`ifdef VSG_PIXEL_COORD_EN
  coord_t pixelXNext_s;
  coord_t pixelYNext_s;
  logic   frameStartNext_s;
  coord_t pixelX_r;
  coord_t pixelY_r;
  logic   frameStart_r;
  logic   unused_s;

  // Coordinates are only meaningful inside the window; hold 0 elsewhere
  always_comb begin
    pixelXNext_s     = 10'd0;
    pixelYNext_s     = 10'd0;
    frameStartNext_s = 1'b0;
    if (blankNext_s) begin
      pixelXNext_s = hOffset_s;
      pixelYNext_s = vOffset_s;
    end else begin
      pixelXNext_s = 10'd0;
      pixelYNext_s = 10'd0;
    end
    if ((hCount_s == 10'd0) && (vCount_s == 10'd0)) begin
      frameStartNext_s = 1'b1;
    end else begin
      frameStartNext_s = 1'b0;
    end
  end

  // Coordinate and frame-start output registers
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pixelX_r     <= 10'd0;
      pixelY_r     <= 10'd0;
      frameStart_r <= 1'b0;
    end else begin
      pixelX_r     <= pixelXNext_s;
      pixelY_r     <= pixelYNext_s;
      frameStart_r <= frameStartNext_s;
    end
  end

  assign pixel_x     = pixelX_r;
  assign pixel_y     = pixelY_r;
  assign frame_start = frameStart_r;
  assign unused_s    = vWrap_s;
`else
  // Counter taps that only feed the coordinate outputs
  logic unused_s;
  assign unused_s = ^{vWrap_s, hCount_s, vCount_s, hOffset_s, vOffset_s};
`endif

endmodule

// File: tb/tb_video_sync_generator.sv
// tb_video_sync_generator: compares three generator instances (default
// timing, 320x240 active, and a tiny raster that completes many frames)
// against a cycle-index reference model, with randomized reset points.
module tb_video_sync_generator;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
  } exp_t;

  logic clk;
  logic reset;

  logic hs0, vs0, bl0;
  logic hs1, vs1, bl1;
  logic hs2, vs2, bl2;
`ifdef VSG_PIXEL_COORD_EN
  logic [9:0] px0, py0, px1, py1, px2, py2;
  logic       fs0, fs1, fs2;
`endif

  int  n;
  bit  in_rst;
  int  checks;
  int  fails;

  // Default raster
  video_sync_generator u_dut0 (
    .vga_clk(clk), .reset(reset), .blank_n(bl0), .HS(hs0), .VS(vs0)
`ifdef VSG_PIXEL_COORD_EN
    , .pixel_x(px0), .pixel_y(py0), .frame_start(fs0)
`endif
  );

  // Reduced active area
  video_sync_generator #(.H_ACTIVE(320), .V_ACTIVE(240)) u_dut1 (
    .vga_clk(clk), .reset(reset), .blank_n(bl1), .HS(hs1), .VS(vs1)
`ifdef VSG_PIXEL_COORD_EN
    , .pixel_x(px1), .pixel_y(py1), .frame_start(fs1)
`endif
  );

  // Tiny raster: 17 x 10, frame of 170 clocks
  video_sync_generator #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(1)
  ) u_dut2 (
    .vga_clk(clk), .reset(reset), .blank_n(bl2), .HS(hs2), .VS(vs2)
`ifdef VSG_PIXEL_COORD_EN
    , .pixel_x(px2), .pixel_y(py2), .frame_start(fs2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n edges since reset release
  function automatic exp_t model(int hsy, int hbk, int hac, int hfr,
                                 int vsy, int vbk, int vac, int vfr,
                                 int edges, bit rst_now);
    exp_t e;
    int ht, vt, pos, h, v, hst, vst;
    bit ha, va;
    e = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0, px: 10'd0, py: 10'd0};
    if (rst_now || edges == 0) return e;
    ht  = hsy + hbk + hac + hfr;
    vt  = vsy + vbk + vac + vfr;
    pos = (edges - 1) % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    hst = hsy + hbk;
    vst = vsy + vbk;
    ha  = (h >= hst) && (h < hst + hac);
    va  = (v >= vst) && (v < vst + vac);
    e.hs = (h >= hsy);
    e.vs = (v >= vsy);
    e.bl = ha && va;
    e.fs = (pos == 0);
    e.px = e.bl ? 10'(h - hst) : 10'd0;
    e.py = e.bl ? 10'(v - vst) : 10'd0;
    return e;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b edge=%0d", tag, obs, expv, n);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, expv, n);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = model(96, 48, 640, 16, 2, 33, 480, 10, n, in_rst);
    chk1("d0_hs", hs0, e.hs); chk1("d0_vs", vs0, e.vs); chk1("d0_blank", bl0, e.bl);
`ifdef VSG_PIXEL_COORD_EN
    chk1("d0_fs", fs0, e.fs); chkn("d0_px", int'(px0), int'(e.px)); chkn("d0_py", int'(py0), int'(e.py));
`endif
    e = model(96, 48, 320, 16, 2, 33, 240, 10, n, in_rst);
    chk1("d1_hs", hs1, e.hs); chk1("d1_vs", vs1, e.vs); chk1("d1_blank", bl1, e.bl);
`ifdef VSG_PIXEL_COORD_EN
    chk1("d1_fs", fs1, e.fs); chkn("d1_px", int'(px1), int'(e.px)); chkn("d1_py", int'(py1), int'(e.py));
`endif
    e = model(4, 3, 8, 2, 2, 2, 5, 1, n, in_rst);
    chk1("d2_hs", hs2, e.hs); chk1("d2_vs", vs2, e.vs); chk1("d2_blank", bl2, e.bl);
`ifdef VSG_PIXEL_COORD_EN
    chk1("d2_fs", fs2, e.fs); chkn("d2_px", int'(px2), int'(e.px)); chkn("d2_py", int'(py2), int'(e.py));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_all();
  endtask

  // Measurement state for run-length checks
  logic p_hs0, p_bl0, p_hs1, p_bl1, p_vs2, p_bl2;
  int fall0, rise0, per0, hslow0, gap0, blen0;
  int fall1, rise1, per1, gap1, blen1;
  int vfall2, have2, acc_vs2, acc_bl2, acc_ln2, f_vs2, f_bl2, f_ln2, f_per2;

  initial begin
    int len;
    checks = 0;
    fails  = 0;
    n      = 0;
    in_rst = 1'b0;
    reset  = 1'b0;

    // Power-up reset: async effect before any clock edge, then held
    #1;
    reset  = 1'b1;
    in_rst = 1'b1;
    #1;
    check_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();

    // Free run from release, measuring line and frame structure
    reset  = 1'b0;
    in_rst = 1'b0;
    n      = 0;
    p_hs0 = 1'b1; p_bl0 = 1'b0; p_hs1 = 1'b1; p_bl1 = 1'b0; p_vs2 = 1'b1; p_bl2 = 1'b0;
    fall0 = -1; rise0 = -1; per0 = -1; hslow0 = -1; gap0 = -1; blen0 = -1;
    fall1 = -1; rise1 = -1; per1 = -1; gap1 = -1; blen1 = -1;
    vfall2 = -1; have2 = 0; acc_vs2 = 0; acc_bl2 = 0; acc_ln2 = 0;
    f_vs2 = -1; f_bl2 = -1; f_ln2 = -1; f_per2 = -1;
    repeat (29700) begin
      step();
      if (p_hs0 && !hs0) begin
        if (fall0 >= 0) per0 = n - fall0;
        fall0 = n;
      end
      if (!p_hs0 && hs0) hslow0 = n - fall0;
      if (!p_bl0 && bl0) begin gap0 = n - fall0; rise0 = n; end
      if (p_bl0 && !bl0) blen0 = n - rise0;
      if (p_hs1 && !hs1) begin
        if (fall1 >= 0) per1 = n - fall1;
        fall1 = n;
      end
      if (!p_bl1 && bl1) begin gap1 = n - fall1; rise1 = n; end
      if (p_bl1 && !bl1) blen1 = n - rise1;
      if (p_vs2 && !vs2) begin
        if (have2 != 0) begin
          f_vs2 = acc_vs2; f_bl2 = acc_bl2; f_ln2 = acc_ln2; f_per2 = n - vfall2;
        end
        have2 = 1; vfall2 = n; acc_vs2 = 0; acc_bl2 = 0; acc_ln2 = 0;
      end
      if (!vs2) acc_vs2++;
      if (bl2) acc_bl2++;
      if (!p_bl2 && bl2) acc_ln2++;
      p_hs0 = hs0; p_bl0 = bl0; p_hs1 = hs1; p_bl1 = bl1; p_vs2 = vs2; p_bl2 = bl2;
    end
    chkn("d0_line_period", per0, 800);
    chkn("d0_hs_low", hslow0, 96);
    chkn("d0_blank_gap", gap0, 144);
    chkn("d0_blank_len", blen0, 640);
    chkn("d1_line_period", per1, 480);
    chkn("d1_blank_gap", gap1, 144);
    chkn("d1_blank_len", blen1, 320);
    chkn("d2_vs_low_clocks", f_vs2, 2 * 17);
    chkn("d2_blank_clocks", f_bl2, 5 * 8);
    chkn("d2_blank_lines", f_ln2, 5);
    chkn("d2_frame_period", f_per2, 170);

    // Restart, then reset mid-line at h_cnt = 300
    #2;
    reset  = 1'b1;
    in_rst = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    reset  = 1'b0;
    in_rst = 1'b0;
    n      = 0;
    repeat (300) step();
    chk1("pre_reset_vs_low", vs0, 1'b0);
    #2;
    reset  = 1'b1;
    in_rst = 1'b1;
    #1;
    chk1("midline_async_hs", hs0, 1'b1);
    chk1("midline_async_vs", vs0, 1'b1);
    chk1("midline_async_blank", bl0, 1'b0);
    check_all();
    @(negedge clk);
    reset  = 1'b0;
    in_rst = 1'b0;
    n      = 0;
    step();
    chk1("first_edge_hs", hs0, 1'b0);
    chk1("first_edge_vs", vs0, 1'b0);
`ifdef VSG_PIXEL_COORD_EN
    chk1("first_edge_fs", fs0, 1'b1);
`endif

    // Randomized free-run lengths and reset points
    for (int it = 0; it < 5; it++) begin
      len = int'($urandom_range(1, 700));
      repeat (len) step();
      #($urandom_range(1, 3));
      reset  = 1'b1;
      in_rst = 1'b1;
      #1;
      check_all();
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_all();
      end
      @(negedge clk);
      reset  = 1'b0;
      in_rst = 1'b0;
      n      = 0;
    end
    repeat (500) step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
